if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage with IF/ID pipeline register for the MIPS core. Holds the PC, drives a req/ack instruction-memory port, and presents the fetched word, PC+4 and opcode field to decode, where the main control decoder consumes `if_opcode`. Handles decode stalls with a one-entry skid buffer and redirects for taken branches and jumps. Branches have no delay slot.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- One clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous active-high reset.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  word address, equal to `pc`.
- `imem_ack`  in  1  data valid this cycle for the outstanding request.
- `imem_rdata`  in  32  instruction word.
- `stall`  in  1  hazard unit: hold IF/ID.
- `branch_taken`  in  1  EX-stage taken branch (Branch & zero).
- `branch_target`  in  32  branch destination.
- `jump`  in  1  Jump from the control decoder for the instruction in IF/ID.
- `pc`  out  32  current fetch PC.
- `if_valid`  out  1  IF/ID holds a live instruction.
- `if_instr`  out  32  IF/ID instruction.
- `if_pc4`  out  32  IF/ID PC+4.
- `if_opcode`  out  6  `if_instr[31:26]`.

## Operation
- States: FETCH (request outstanding), DRAIN (discard in-flight response after redirect), WAIT (skid full, no request).
- `imem_req` = (state is FETCH or DRAIN) and !rst. `imem_req` and `imem_addr` stay stable until `imem_ack`.
- Redirect priority: `branch_taken` over `jump`.
  - `jump` is honoured only when `if_valid` and !`stall`.
  - Jump target = {if_pc4[31:28], if_instr[25:0], 2'b00}.
- On redirect:
  - `pc` <= target, `if_valid` <= 0, skid cleared.
  - With an ack in the same cycle: data dropped, next state FETCH.
  - In FETCH without ack: next state DRAIN. DRAIN holds the old address until ack, drops the data, then goes to FETCH with the new `pc`.
  - In WAIT: next state FETCH.
- FETCH, ack, no redirect:
  - `pc` <= pc+4.
  - If !`stall`: IF/ID <= {1, rdata, pc+4}.
  - If `stall`: skid <= {rdata, pc+4}, next state WAIT.
- WAIT with !`stall`: IF/ID <= skid, skid emptied, next state FETCH.
- `stall`=1 holds IF/ID unconditionally, even when `if_valid`=0.
- Arithmetic: PC+4 is 32-bit modulo, so 32'hFFFF_FFFC wraps to 0. Bits [1:0] are never checked.
- Flushing later stages is outside this block.

## Timing
- Reset values:
  - `pc`=RESET_PC, state FETCH.
  - `if_valid`=0, `if_instr`=0, `if_pc4`=0, `if_opcode`=0.
  - Skid empty, `imem_req`=0 during the reset cycle.
- Reset during an outstanding request abandons it. The memory must ignore a dropped request.
- All outputs except `imem_req` are registered.
- Latency: an ack in cycle N gives `if_valid` in cycle N+1. With single-cycle ack, throughput is one instruction per cycle.
- A redirect in cycle N puts the target on `imem_addr` in N+1, or one cycle after the DRAIN ack.
- Simultaneous ack+stall+redirect: the redirect wins and the data is dropped.

## Structure
- Shared package `mips_pkg`:
  - fetch state enum.
  - `OP_J` = 6'b000010.
  - default `RESET_PC`.
  - instruction field slice constants.
- Sub-module `if_skid_buf`: one-entry buffer, {instr, pc4}, with load/unload/clear and a full flag.

## Test plan
- Reset, then ack every cycle with rdata=addr^32'hA5A5_0000 -> `imem_addr` steps 0,4,8. `if_instr` follows one cycle later, `if_pc4`=addr+4.
- Stall during an acked fetch at 0x8, held for 3 cycles -> IF/ID keeps the 0x4 word, skid holds the 0x8 word, `imem_req`=0. After release, the 0x8 word appears and the next request is 0xC.
- `branch_taken` with target 0x100 while 0x10 is outstanding without ack, ack 2 cycles later -> returned data dropped, `if_valid`=0, next `imem_addr`=0x100.
- IF/ID holds 0x0800_0040 with `if_pc4`=0x1000_0008 and `jump`=1 -> next `pc`=0x1000_0100. The same case with `stall`=1 -> no jump.
- `branch_taken` and `jump` in the same cycle -> `pc`=`branch_target`.
- `pc`=32'hFFFF_FFFC, ack -> `pc` wraps to 0 and `if_pc4`=0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS core front end.
//   - fetch FSM state encoding
//   - instruction field positions and the J opcode
//   - default reset PC and the skid-buffer payload
package mips_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned OP_W        = 6;

    // Instruction field slices
    localparam int unsigned OPCODE_MSB  = 31;
    localparam int unsigned OPCODE_LSB  = 26;
    localparam int unsigned JTARGET_MSB = 25;
    localparam int unsigned JTARGET_LSB = 0;

    localparam logic [OP_W-1:0] OP_J             = 6'b000010;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // S_FETCH: request outstanding; S_DRAIN: discard stale response; S_WAIT: skid full
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DRAIN = 2'd1,
        S_WAIT  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
    } skid_entry_t;

endpackage

// File: rtl/if_skid_buf.sv
// if_skid_buf: one-entry holding buffer for a fetched word that arrives while
// decode is stalled.
//   clk, rst      clock, synchronous active-high reset
//   load          capture din (sets full)
//   unload        entry consumed (clears full)
//   clear         discard entry; wins over load/unload
//   din / dout    {instr, pc4} payload
//   full          entry valid
module if_skid_buf
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  skid_entry_t din,
    output logic        full,
    output skid_entry_t dout
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            full <= 1'b0;
            dout <= '0;
        end else if (load) begin
            full <= 1'b1;
            dout <= din;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch with IF/ID pipeline register.
//   clk, rst                 clock, synchronous active-high reset
//   imem_req/addr/ack/rdata  req/ack instruction memory port
//   stall                    hold IF/ID (hazard unit)
//   branch_taken/target      EX-stage redirect, highest priority
//   jump                     J decoded from IF/ID, honoured when live and not stalled
//   pc                       current fetch PC
//   if_valid/instr/pc4       IF/ID register
//   if_opcode                opcode field of if_instr
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    output logic [31:0] pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc4,
    output logic [5:0]  if_opcode
);

    fetch_state_t state;

    logic        jump_ok;
    logic        redirect;
    logic [31:0] jump_target;
    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;

    logic        skid_load;
    logic        skid_unload;
    logic        skid_full;
    skid_entry_t skid_in;
    skid_entry_t skid_out;

    assign pc_plus4        = pc + 32'd4;
    assign jump_target     = {if_pc4[31:28], if_instr[JTARGET_MSB:JTARGET_LSB], 2'b00};
    assign jump_ok         = jump && if_valid && !stall;
    assign redirect        = branch_taken || jump_ok;
    assign redirect_target = branch_taken ? branch_target : jump_target;

    // Request is live in FETCH and DRAIN; the reset cycle never requests.
    assign imem_req  = ((state == S_FETCH) || (state == S_DRAIN)) && !rst;
    assign if_opcode = if_instr[OPCODE_MSB:OPCODE_LSB];

    assign skid_in     = {imem_rdata, pc_plus4};
    assign skid_load   = (state == S_FETCH) && imem_ack && !redirect && stall;
    assign skid_unload = (state == S_WAIT) && skid_full && !stall && !redirect;

    if_skid_buf u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .unload (skid_unload),
        .clear  (redirect),
        .din    (skid_in),
        .full   (skid_full),
        .dout   (skid_out)
    );

    // imem_addr is tracked separately from pc so DRAIN can hold the old address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            imem_addr <= RESET_PC;
            if_valid  <= 1'b0;
            if_instr  <= '0;
            if_pc4    <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (redirect) begin
                        pc       <= redirect_target;
                        if_valid <= 1'b0;
                        if (imem_ack) begin
                            imem_addr <= redirect_target;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end else if (imem_ack) begin
                        pc        <= pc_plus4;
                        imem_addr <= pc_plus4;
                        if (!stall) begin
                            if_valid <= 1'b1;
                            if_instr <= imem_rdata;
                            if_pc4   <= pc_plus4;
                        end else begin
                            state <= S_WAIT;
                        end
                    end else if (!stall) begin
                        if_valid <= 1'b0;
                    end
                end

                S_DRAIN: begin
                    if (redirect) begin
                        pc       <= redirect_target;
                        if_valid <= 1'b0;
                        if (imem_ack) begin
                            imem_addr <= redirect_target;
                            state     <= S_FETCH;
                        end
                    end else if (imem_ack) begin
                        // stale word dropped; start fetching the redirected pc
                        imem_addr <= pc;
                        state     <= S_FETCH;
                    end
                end

                S_WAIT: begin
                    if (redirect) begin
                        pc        <= redirect_target;
                        imem_addr <= redirect_target;
                        if_valid  <= 1'b0;
                        state     <= S_FETCH;
                    end else if (!stall) begin
                        if_valid <= 1'b1;
                        if_instr <= skid_out.instr;
                        if_pc4   <= skid_out.pc4;
                        state    <= S_FETCH;
                    end
                end

                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed test-plan scenarios followed by random traffic, all
// checked every cycle against a queue-based fetch model.
module tb_if_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
    logic [5:0]  if_opcode;

    int tests  = 0;
    int failed = 0;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .pc            (pc),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc4        (if_pc4),
        .if_opcode     (if_opcode)
    );

    always #5 clk = ~clk;

    // Reference model: next fetch pc, address on the bus, whether the
    // outstanding response is stale, a queue of parked words, and IF/ID.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ent_t;

    logic [31:0] m_pc, m_addr, m_instr, m_pc4;
    logic        m_drop, m_valid;
    ent_t        m_buf[$];

    task automatic model_reset();
        m_pc = 32'h0; m_addr = 32'h0; m_drop = 1'b0;
        m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
        m_buf.delete();
    endtask

    task automatic model_step();
        logic        req;
        logic        redir;
        logic [31:0] tgt;
        ent_t        w;
        if (rst) begin
            model_reset();
        end else begin
            req   = (m_buf.size() == 0);
            redir = branch_taken || (jump && m_valid && !stall);
            tgt   = branch_taken ? branch_target : {m_pc4[31:28], m_instr[25:0], 2'b00};
            if (redir) begin
                m_pc = tgt; m_valid = 1'b0; m_buf.delete();
                if (req && !imem_ack) m_drop = 1'b1;
                else begin m_drop = 1'b0; m_addr = tgt; end
            end else if (req && imem_ack) begin
                if (m_drop) begin
                    m_drop = 1'b0; m_addr = m_pc;
                end else begin
                    w.instr = imem_rdata; w.pc4 = m_addr + 32'd4;
                    m_pc = w.pc4; m_addr = w.pc4;
                    if (stall) m_buf.push_back(w);
                    else begin m_valid = 1'b1; m_instr = w.instr; m_pc4 = w.pc4; end
                end
            end else if (m_buf.size() != 0 && !stall) begin
                w = m_buf.pop_front();
                m_valid = 1'b1; m_instr = w.instr; m_pc4 = w.pc4;
            end else if (!stall) begin
                m_valid = 1'b0;
            end
        end
    endtask

    function automatic logic [31:0] mw();
        return m_addr ^ KEY;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic req_exp;
        req_exp = !rst && (m_buf.size() == 0);
        chk("pc",        pc,                 m_pc);
        chk("imem_addr", imem_addr,          m_addr);
        chk("imem_req",  32'(imem_req),      32'(req_exp));
        chk("if_valid",  32'(if_valid),      32'(m_valid));
        chk("if_instr",  if_instr,           m_instr);
        chk("if_pc4",    if_pc4,             m_pc4);
        chk("if_opcode", 32'(if_opcode),     32'(m_instr[31:26]));
    endtask

    // Apply inputs, clock once, advance the model, then compare.
    task automatic step(input logic r, input logic a, input logic s, input logic b,
                        input logic [31:0] bt, input logic j, input logic [31:0] d);
        rst = r; imem_ack = a; stall = s; branch_taken = b;
        branch_target = bt; jump = j; imem_rdata = d;
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        branch_target = 32'h0; jump = 1'b0; imem_rdata = 32'h0;
        model_reset();

        // Reset
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_req",   32'(imem_req), 32'h0);
        chk("rst_pc",    pc,            32'h0);
        chk("rst_valid", 32'(if_valid), 32'h0);
        step(1, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("addr0", imem_addr, 32'h0);
        chk("req0",  32'(imem_req), 32'h1);

        // Sequential fetch, single-cycle ack
        step(0, 1, 0, 0, 0, 0, mw());
        chk("addr4",  imem_addr, 32'h4);
        chk("instr0", if_instr,  32'hA5A5_0000);
        chk("pc4_0",  if_pc4,    32'h4);
        step(0, 1, 0, 0, 0, 0, mw());
        chk("addr8",  imem_addr, 32'h8);
        chk("instr4", if_instr,  32'hA5A5_0004);

        // Stall during the acked fetch at 0x8, held 3 cycles
        step(0, 1, 1, 0, 0, 0, mw());
        chk("stall_instr", if_instr,       32'hA5A5_0004);
        chk("stall_req",   32'(imem_req),  32'h0);
        step(0, 0, 1, 0, 0, 0, mw());
        step(0, 0, 1, 0, 0, 0, mw());
        chk("stall_hold",  if_instr,       32'hA5A5_0004);
        step(0, 0, 0, 0, 0, 0, mw());
        chk("skid_instr",  if_instr,       32'hA5A5_0008);
        chk("skid_valid",  32'(if_valid),  32'h1);
        chk("next_addr",   imem_addr,      32'hC);

        // Branch while 0x10 outstanding, ack two cycles later
        step(0, 1, 0, 0, 0, 0, mw());
        chk("addr10", imem_addr, 32'h10);
        step(0, 0, 0, 1, 32'h100, 0, mw());
        chk("drain_addr",  imem_addr,     32'h10);
        chk("drain_valid", 32'(if_valid), 32'h0);
        step(0, 0, 0, 0, 0, 0, mw());
        step(0, 1, 0, 0, 0, 0, mw());
        chk("br_addr",  imem_addr,     32'h100);
        chk("br_valid", 32'(if_valid), 32'h0);

        // Jump: IF/ID = 0x0800_0040 with pc4 0x1000_0008
        step(0, 0, 0, 1, 32'h1000_0004, 0, mw());
        step(0, 1, 0, 0, 0, 0, mw());
        step(0, 1, 0, 0, 0, 0, 32'h0800_0040);
        chk("j_pc4",    if_pc4,          32'h1000_0008);
        chk("j_opcode", 32'(if_opcode),  32'h2);
        step(0, 0, 1, 0, 0, 1, mw());
        chk("j_stall_pc", pc, 32'h1000_0008);
        step(0, 0, 0, 0, 0, 1, mw());
        chk("j_pc", pc, 32'h1000_0100);

        // Branch and jump together: branch wins
        step(0, 1, 0, 0, 0, 0, mw());
        step(0, 1, 0, 0, 0, 0, 32'h0800_0040);
        step(0, 0, 0, 1, 32'h2000, 1, mw());
        chk("br_over_j", pc, 32'h2000);

        // PC wrap
        step(0, 0, 0, 1, 32'hFFFF_FFFC, 0, mw());
        step(0, 1, 0, 0, 0, 0, mw());
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        step(0, 1, 0, 0, 0, 0, mw());
        chk("wrap_pc",  pc,     32'h0);
        chk("wrap_pc4", if_pc4, 32'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic r, a, s, b, j;
            logic [31:0] bt;
            r  = ($urandom_range(0, 99) < 1);
            a  = ($urandom_range(0, 99) < 70) && (m_buf.size() == 0);
            s  = ($urandom_range(0, 99) < 30);
            b  = ($urandom_range(0, 99) < 8);
            j  = ($urandom_range(0, 99) < 15);
            bt = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) begin
                step(r, a, s, b, bt, j, $urandom());
            end else begin
                step(r, a, s, b, bt, j, mw());
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
